// File: rtl/image_transfer_controller.sv
// SPI-driven image transfer controller: command/header decode, BRAM write and
// prefetching read paths, and a status readback byte.
module image_transfer_controller #(
    parameter int unsigned ADDR_W    = 17,
    parameter int unsigned CH_W      = 2,
    parameter int unsigned MEM_DEPTH = 76800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_cs_n,
    input  logic              spi_byte_valid,
    input  logic [7:0]        spi_byte_in,
    output logic [7:0]        spi_byte_out,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [CH_W-1:0]   bram_channel,
    output logic              bram_we,
    output logic [7:0]        bram_data_in,
    input  logic [7:0]        bram_data_out,
    output logic [2:0]        state,
    output logic              busy,
    output logic              err
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR    = 3'd1,
        WRITE  = 3'd2,
        READ   = 3'd3,
        STATUS = 3'd4
    } state_t;

    state_t             state_q, state_n;
    logic [1:0]         op_q, op_n;
    logic [1:0]         hdr_cnt_q, hdr_cnt_n;
    logic [15:0]        height_q, height_n;
    logic [7:0]         width_hi_q, width_hi_n;
    logic [CNT_W-1:0]   remaining_q, remaining_n;
    logic [1:0]         rd_pipe_q, rd_pipe_n;
    logic [7:0]         out_n;
    logic [ADDR_W-1:0]  addr_n;
    logic [CH_W-1:0]    ch_n;
    logic               we_n;
    logic [7:0]         din_n;
    logic               busy_n;
    logic               err_n;
    logic               take_c;
    logic [31:0]        len_c;

    assign state  = state_q;
    assign take_c = spi_byte_valid & ~spi_cs_n;
    assign len_c  = 32'(height_q) * 32'({width_hi_q, spi_byte_in});

    // Next-state and next-output logic
    always_comb begin
        state_n     = state_q;
        op_n        = op_q;
        hdr_cnt_n   = hdr_cnt_q;
        height_n    = height_q;
        width_hi_n  = width_hi_q;
        remaining_n = remaining_q;
        rd_pipe_n   = {rd_pipe_q[0], 1'b0};
        out_n       = spi_byte_out;
        addr_n      = bram_addr;
        ch_n        = bram_channel;
        we_n        = 1'b0;
        din_n       = bram_data_in;
        err_n       = err;

        // Capture BRAM read data two clocks after an address update
        if (rd_pipe_q[1]) begin
            out_n = bram_data_out;
        end

        if (spi_cs_n) begin
            state_n     = IDLE;
            hdr_cnt_n   = 2'd0;
            remaining_n = '0;
            rd_pipe_n   = 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take_c) begin
                        op_n = spi_byte_in[7:6];
                        case (spi_byte_in[7:6])
                            2'b00: err_n = 1'b0;
                            2'b01, 2'b10: begin
                                ch_n      = spi_byte_in[CH_W-1:0];
                                hdr_cnt_n = 2'd0;
                                state_n   = HDR;
                            end
                            2'b11: begin
                                out_n   = {err, 3'b000, state_q, 1'b0};
                                state_n = STATUS;
                            end
                        endcase
                    end
                end
                HDR: begin
                    if (take_c) begin
                        hdr_cnt_n = hdr_cnt_q + 2'd1;
                        case (hdr_cnt_q)
                            2'd0: height_n[15:8] = spi_byte_in;
                            2'd1: height_n[7:0]  = spi_byte_in;
                            2'd2: width_hi_n     = spi_byte_in;
                            2'd3: begin
                                if ((len_c == 32'd0) || (len_c > 32'(MEM_DEPTH))) begin
                                    err_n   = 1'b1;
                                    state_n = IDLE;
                                end else begin
                                    remaining_n = CNT_W'(len_c);
                                    addr_n      = '0;
                                    if (op_q == 2'b01) begin
                                        state_n = WRITE;
                                    end else begin
                                        state_n   = READ;
                                        rd_pipe_n = 2'b01;
                                    end
                                end
                            end
                        endcase
                    end
                end
                WRITE: begin
                    // A write pulse is followed by an address bump; the last
                    // pulse still belongs to WRITE so bram_we never leaks out.
                    if (bram_we) begin
                        addr_n = bram_addr + ADDR_W'(1);
                        if (remaining_q == '0) begin
                            state_n = IDLE;
                        end
                    end else if (take_c) begin
                        we_n        = 1'b1;
                        din_n       = spi_byte_in;
                        remaining_n = remaining_q - CNT_W'(1);
                    end
                end
                READ: begin
                    if (take_c) begin
                        if (remaining_q == CNT_W'(1)) begin
                            remaining_n = '0;
                            rd_pipe_n   = 2'b00;
                            state_n     = IDLE;
                        end else begin
                            addr_n      = bram_addr + ADDR_W'(1);
                            remaining_n = remaining_q - CNT_W'(1);
                            rd_pipe_n   = 2'b01;
                        end
                    end
                end
                STATUS: begin
                    if (take_c) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        busy_n = (state_n != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= 2'b00;
            hdr_cnt_q    <= 2'd0;
            height_q     <= 16'd0;
            width_hi_q   <= 8'd0;
            remaining_q  <= '0;
            rd_pipe_q    <= 2'b00;
            spi_byte_out <= 8'd0;
            bram_addr    <= '0;
            bram_channel <= '0;
            bram_we      <= 1'b0;
            bram_data_in <= 8'd0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state_q      <= state_n;
            op_q         <= op_n;
            hdr_cnt_q    <= hdr_cnt_n;
            height_q     <= height_n;
            width_hi_q   <= width_hi_n;
            remaining_q  <= remaining_n;
            rd_pipe_q    <= rd_pipe_n;
            spi_byte_out <= out_n;
            bram_addr    <= addr_n;
            bram_channel <= ch_n;
            bram_we      <= we_n;
            bram_data_in <= din_n;
            busy         <= busy_n;
            err          <= err_n;
        end
    end

endmodule

// File: tb/tb_image_transfer_controller.sv
// Scoreboard bench for image_transfer_controller: directed SPI transactions,
// expected BRAM writes and SPI output bytes checked by an independent monitor.
module tb_image_transfer_controller;

    localparam int unsigned ADDR_W = 17;
    localparam int unsigned CH_W   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              spi_cs_n;
    logic              spi_byte_valid;
    logic [7:0]        spi_byte_in;
    logic [7:0]        spi_byte_out;
    logic [ADDR_W-1:0] bram_addr;
    logic [CH_W-1:0]   bram_channel;
    logic              bram_we;
    logic [7:0]        bram_data_in;
    logic [7:0]        bram_data_out = 8'd0;
    logic [2:0]        state;
    logic              busy;
    logic              err;

    int tests = 0;
    int fails = 0;

    logic [31:0] wr_q[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  mem [0:3][0:63];

    image_transfer_controller #(.ADDR_W(ADDR_W), .CH_W(CH_W), .MEM_DEPTH(76800)) dut (
        .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_byte_valid(spi_byte_valid),
        .spi_byte_in(spi_byte_in), .spi_byte_out(spi_byte_out), .bram_addr(bram_addr),
        .bram_channel(bram_channel), .bram_we(bram_we), .bram_data_in(bram_data_in),
        .bram_data_out(bram_data_out), .state(state), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Synchronous-read BRAM model
    always @(posedge clk) bram_data_out <= mem[bram_channel][bram_addr[5:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write pulse and every consumed read/status frame is scored
    always @(negedge clk) begin
        if (!rst) begin
            if (bram_we) begin
                if (wr_q.size() == 0) chk("unexpected_write", {8'(bram_channel), 16'(bram_addr), bram_data_in}, 32'hFFFF_FFFF);
                else chk("bram_write", {8'(bram_channel), 16'(bram_addr), bram_data_in}, wr_q.pop_front());
            end
            if (spi_byte_valid && !spi_cs_n && (state == 3'd3 || state == 3'd4)) begin
                if (rd_q.size() == 0) chk("unexpected_frame", 32'(spi_byte_out), 32'h1FF);
                else chk("spi_out", 32'(spi_byte_out), 32'(rd_q.pop_front()));
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        spi_byte_in    = b;
        spi_byte_valid = 1'b1;
        @(posedge clk); #1;
        spi_byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_hdr(input logic [7:0] h1, input logic [7:0] h0, input logic [7:0] w1, input logic [7:0] w0);
        send(h1); send(h0); send(w1); send(w0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < 64; a++) mem[c][a] = 8'(c * 16 + a);
        mem[2][0] = 8'hA0; mem[2][1] = 8'hA1; mem[2][2] = 8'hA2; mem[2][3] = 8'hA3;

        rst = 1'b1; spi_cs_n = 1'b1; spi_byte_valid = 1'b0; spi_byte_in = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_out", 32'(spi_byte_out), 32'd0);
        chk("rst_addr", 32'(bram_addr), 32'd0);
        chk("rst_we", 32'(bram_we), 32'd0);
        rst = 1'b0; spi_cs_n = 1'b0;
        @(posedge clk); #1;

        // Write 6 bytes to channel 1
        send(8'h41);
        chk("w_hdr_state", 32'(state), 32'd1);
        chk("w_busy", 32'(busy), 32'd1);
        send_hdr(8'h00, 8'h02, 8'h00, 8'h03);
        chk("w_state", 32'(state), 32'd2);
        for (int i = 0; i < 6; i++) begin
            wr_q.push_back({8'd1, 16'(i), 8'(8'h10 + i)});
            send(8'(8'h10 + i));
        end
        chk("w_end_state", 32'(state), 32'd0);
        chk("w_end_busy", 32'(busy), 32'd0);

        // Read 4 bytes from channel 2
        send(8'h82);
        send_hdr(8'h00, 8'h01, 8'h00, 8'h04);
        chk("r_state", 32'(state), 32'd3);
        chk("r_chan", 32'(bram_channel), 32'd2);
        rd_q.push_back(8'hA0); rd_q.push_back(8'hA1); rd_q.push_back(8'hA2); rd_q.push_back(8'hA3);
        for (int i = 0; i < 4; i++) send(8'hFF);
        chk("r_end_state", 32'(state), 32'd0);

        // Zero length header sets err, opcode 00 clears it
        send(8'h41);
        send_hdr(8'h00, 8'h00, 8'h00, 8'h05);
        chk("len0_err", 32'(err), 32'd1);
        chk("len0_state", 32'(state), 32'd0);
        send(8'h00);
        chk("clr_err", 32'(err), 32'd0);

        // Abort a write with spi_cs_n, then restart from address 0
        send(8'h41);
        send_hdr(8'h00, 8'h01, 8'h00, 8'h08);
        for (int i = 0; i < 3; i++) begin
            wr_q.push_back({8'd1, 16'(i), 8'(8'h20 + i)});
            send(8'(8'h20 + i));
        end
        @(posedge clk); #1;
        spi_cs_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_we", 32'(bram_we), 32'd0);
        spi_cs_n = 1'b0;
        send(8'h41);
        send_hdr(8'h00, 8'h01, 8'h00, 8'h02);
        chk("restart_addr", 32'(bram_addr), 32'd0);
        for (int i = 0; i < 2; i++) begin
            wr_q.push_back({8'd1, 16'(i), 8'(8'h30 + i)});
            send(8'(8'h30 + i));
        end
        chk("restart_end", 32'(state), 32'd0);

        // Oversized image: 300*257 = 77100 > 76800
        send(8'h40);
        send_hdr(8'h01, 8'h2C, 8'h01, 8'h01);
        chk("big_err", 32'(err), 32'd1);
        chk("big_state", 32'(state), 32'd0);
        send(8'hC0);
        chk("status_state", 32'(state), 32'd4);
        rd_q.push_back(8'h80);
        send(8'h00);
        chk("status_exit", 32'(state), 32'd0);
        chk("status_err_kept", 32'(err), 32'd1);

        // Reset mid-read with a simultaneous strobe
        send(8'h82);
        send_hdr(8'h00, 8'h01, 8'h00, 8'h04);
        rd_q.push_back(8'hA0);
        send(8'hFF);
        chk("mid_read_state", 32'(state), 32'd3);
        @(posedge clk); #1;
        rst = 1'b1; spi_byte_valid = 1'b1; spi_byte_in = 8'hC0;
        @(posedge clk); #1;
        rst = 1'b0; spi_byte_valid = 1'b0;
        chk("mrst_state", 32'(state), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_err", 32'(err), 32'd0);
        chk("mrst_out", 32'(spi_byte_out), 32'd0);
        chk("mrst_addr", 32'(bram_addr), 32'd0);
        chk("mrst_chan", 32'(bram_channel), 32'd0);
        chk("mrst_we", 32'(bram_we), 32'd0);
        chk("mrst_din", 32'(bram_data_in), 32'd0);
        repeat (3) @(posedge clk); #1;
        chk("mrst_idle_hold", 32'(state), 32'd0);

        chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
